// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt dispatcher.
package irq_pkg;

  localparam int NCHAN = 9;
  localparam int NBUS  = 3;

  localparam int HOLDOFF_CYC_DEF = 4;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef logic [5:0] vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_REQ,
    S_SERVICE,
    S_HOLDOFF
  } state_t;

endpackage

// File: rtl/irq_holdoff_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement, and it
// saturates at zero.
module irq_holdoff_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: 2-cycle stability filter, CPU ack/eoi handshake,
// post-eoi holdoff. Optional ack timeout under IRQ_DISPATCH_TIMEOUT_EN.
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pe_valid,
  input  logic [1:0] pe_bus,
  input  logic [3:0] pe_chan,
  input  logic       cpu_ack,
  input  logic       cpu_eoi,
  output logic       irq_req,
  output vec_t       irq_vec,
  output logic       busy,
  output logic       err_range,
  output logic       err_timeout
);

  state_t     state;
  vec_t       cand;
  vec_t       code;
  logic       legal;
  logic       promote;
  logic       hold_load;
  logic       hold_dec;
  logic [3:0] hold_cnt;
  logic       hold_zero;

  assign code    = {pe_bus, pe_chan};
  assign legal   = (int'(pe_bus) < NBUS) && (int'(pe_chan) < NCHAN);
  assign promote = (state == S_QUAL) && pe_valid && (code == cand);

  assign hold_load = (state == S_SERVICE) && cpu_eoi;
  assign hold_dec  = (state == S_HOLDOFF);

  irq_holdoff_cnt #(.W(4)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (4'(HOLDOFF_CYC)),
    .dec      (hold_dec),
    .count    (hold_cnt),
    .zero     (hold_zero)
  );

`ifdef IRQ_DISPATCH_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_zero;
  logic       tmo_expire;

  irq_holdoff_cnt #(.W(8)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (promote),
    .load_val (8'(TIMEOUT_CYC)),
    .dec      (state == S_REQ),
    .count    (tmo_cnt),
    .zero     (tmo_zero)
  );

  // The decrement in this cycle takes the counter to zero.
  assign tmo_expire = (state == S_REQ) && ((tmo_cnt == 8'd1) || tmo_zero);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cand      <= '0;
      irq_req   <= 1'b0;
      irq_vec   <= '0;
      busy      <= 1'b0;
      err_range <= 1'b0;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pe_valid) begin
            if (legal) begin
              cand  <= code;
              state <= S_QUAL;
            end else begin
              err_range <= 1'b1;
            end
          end
        end
        S_QUAL: begin
          if (pe_valid && !legal) begin
            err_range <= 1'b1;
            state     <= S_IDLE;
          end else if (promote) begin
            irq_vec <= cand;
            irq_req <= 1'b1;
            state   <= S_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          // Ack beats a simultaneous eoi and a simultaneous timeout.
          if (cpu_ack) begin
            irq_req <= 1'b0;
            busy    <= 1'b1;
            state   <= S_SERVICE;
          end
`ifdef IRQ_DISPATCH_TIMEOUT_EN
          else if (tmo_expire) begin
            irq_req     <= 1'b0;
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
`endif
        end
        S_SERVICE: begin
          if (cpu_eoi) begin
            busy  <= 1'b0;
            state <= (HOLDOFF_CYC == 0) ? S_IDLE : S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if ((hold_cnt == 4'd1) || hold_zero) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef IRQ_DISPATCH_TIMEOUT_EN
  assign err_timeout = 1'b0;
`endif

endmodule
